// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter: operation codes and FSM state encoding.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } sh_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter; reports the bit that leaves the register.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] r_next,
    output logic             out_bit
);

    // One-position step selected by op; pass leaves the value untouched
    always_comb begin
        r_next  = r;
        out_bit = 1'b0;
        case (op)
            SH_LSL: begin
                r_next  = {r[WIDTH-2:0], 1'b0};
                out_bit = r[WIDTH-1];
            end
            SH_LSR: begin
                r_next  = {1'b0, r[WIDTH-1:1]};
                out_bit = r[0];
            end
            SH_ASR: begin
                r_next  = {r[WIDTH-1], r[WIDTH-1:1]};
                out_bit = r[0];
            end
            default: begin
                r_next  = r;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Sequential multi-position shifter, one bit per clock, with start/ready and valid/ready handshakes.
// Optional build macro SHIFT_SEQ_CARRY_OUT_EN enables carry_out tracking (tied to 0 otherwise).
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             start_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             carry_out
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [AMT_W-1:0] k_s;
    logic [WIDTH-1:0] step_r_s;
    logic             step_out_s;
    logic             start_ready_q, busy_q, result_valid_q;

    assign k_s = (amt > AMT_MAX) ? AMT_MAX : amt;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .r       (result_q),
        .op      (op_q),
        .r_next  (step_r_s),
        .out_bit (step_out_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        op_d     = op_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    result_d = data_in;
                    op_d     = op;
                    if ((op == SH_PASS) || (k_s == {AMT_W{1'b0}})) begin
                        count_d = {AMT_W{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        count_d = k_s;
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_d = step_r_s;
                count_d  = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake flags; flags are decoded from the next state so they are registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            result_q       <= {WIDTH{1'b0}};
            op_q           <= 2'b00;
            count_q        <= {AMT_W{1'b0}};
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            result_q       <= result_d;
            op_q           <= op_d;
            count_q        <= count_d;
            start_ready_q  <= (state_d == ST_IDLE);
            busy_q         <= (state_d != ST_IDLE);
            result_valid_q <= (state_d == ST_DONE);
        end
    end

`ifdef SHIFT_SEQ_CARRY_OUT_EN
    logic carry_q, carry_d;

    // Carry clears on accept and captures each bit leaving the register while shifting
    always_comb begin
        carry_d = carry_q;
        if ((state_q == ST_IDLE) && start) begin
            carry_d = 1'b0;
        end else if (state_q == ST_SHIFT) begin
            carry_d = step_out_s;
        end else begin
            carry_d = carry_q;
        end
    end

    // Carry register
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;
`else
    // The shifted-out bit is deliberately discarded when carry tracking is off.
    assign carry_out = step_out_s & 1'b0;
`endif

    assign start_ready  = start_ready_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule
